// File: rtl/hazard_scoreboard_pkg.sv
// Shared decode helpers and record types for the hazard scoreboard.
// reg_use() is the single source of truth for operand usage per opcode.
package hazard_scoreboard_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       use1;
      logic       use2;
      logic       wback;
      logic       is_load;
      logic [4:0] rd;
   } reg_use_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] wreg;
      logic       is_load;
   } scb_entry_t;

   function automatic reg_use_t reg_use(input logic [31:0] insn);
      reg_use_t u;
      u     = '0;
      u.rs1 = insn[19:15];
      u.rs2 = insn[24:20];
      u.rd  = insn[11:7];
      case (insn[6:0])
         OPC_OP: begin
            u.use1  = 1'b1;
            u.use2  = 1'b1;
            u.wback = 1'b1;
         end
         OPC_BRANCH, OPC_STORE: begin
            u.use1 = 1'b1;
            u.use2 = 1'b1;
         end
         OPC_OPIMM, OPC_JALR: begin
            u.use1  = 1'b1;
            u.wback = 1'b1;
         end
         OPC_LOAD: begin
            u.use1    = 1'b1;
            u.wback   = 1'b1;
            u.is_load = 1'b1;
         end
         OPC_JAL, OPC_AUIPC, OPC_LUI: u.wback = 1'b1;
         default: ;
      endcase
      // x0 is hardwired zero, so it can never carry a dependency
      if (u.rs1 == 5'd0) u.use1 = 1'b0;
      if (u.rs2 == 5'd0) u.use2 = 1'b0;
      return u;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the decode stage and the hazard scoreboard.
// The scoreboard takes the slave view, decode drives the master view.
interface hazard_scoreboard_if #(
   parameter int NSTAGES = 3,
   parameter int CNTW    = 32
);
   localparam int SW = $clog2(NSTAGES + 1);

   logic [31:0]     i_insn;
   logic            i_valid;
   logic            i_flush;
   logic            o_if_stall;
   logic            o_de_stall;
   logic            o_issue;
   logic [SW-1:0]   o_fwd_rs1;
   logic [SW-1:0]   o_fwd_rs2;
   logic [CNTW-1:0] o_stall_cycles;

   modport master (
      output i_insn, i_valid, i_flush,
      input  o_if_stall, o_de_stall, o_issue,
      input  o_fwd_rs1, o_fwd_rs2, o_stall_cycles
   );

   modport slave (
      input  i_insn, i_valid, i_flush,
      output o_if_stall, o_de_stall, o_issue,
      output o_fwd_rs1, o_fwd_rs2, o_stall_cycles
   );
endinterface

// File: rtl/hazard_scoreboard_reg_use_decode.sv
// Combinational operand-usage decoder; also used by the dual-issue check.
module reg_use_decode
   import hazard_scoreboard_pkg::*;
(
   input  logic [31:0] i_insn,
   output reg_use_t    o_use
);
   assign o_use = reg_use(i_insn);
endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: shadow pipeline of in-flight destinations,
// bypass selects plus load-use stall, or stall-only on any RAW match.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int NSTAGES = 3,
   parameter int FORWARD = 1,
   parameter int CNTW    = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   hazard_scoreboard_if.slave   bus
);
   localparam int SW = $clog2(NSTAGES + 1);

   scb_entry_t      r_scb [NSTAGES];
   logic [CNTW-1:0] r_cnt;

   reg_use_t      w_use;
   logic [SW-1:0] w_sel1, w_sel2;
   logic          w_hit1, w_hit2;
   logic          w_ld1, w_ld2;
   logic          w_live, w_stall, w_issue;

   reg_use_decode u_dec (
      .i_insn (bus.i_insn),
      .o_use  (w_use)
   );

   // Walk oldest to youngest so the youngest match overwrites older ones
   always_comb begin
      w_sel1 = '0;
      w_sel2 = '0;
      w_hit1 = 1'b0;
      w_hit2 = 1'b0;
      w_ld1  = 1'b0;
      w_ld2  = 1'b0;
      for (int k = NSTAGES - 1; k >= 0; k--) begin
         if (r_scb[k].valid && w_use.use1 &&
             r_scb[k].wreg == w_use.rs1) begin
            w_hit1 = 1'b1;
            w_sel1 = SW'(k + 1);
            w_ld1  = (k == 0) && r_scb[k].is_load;
         end
         if (r_scb[k].valid && w_use.use2 &&
             r_scb[k].wreg == w_use.rs2) begin
            w_hit2 = 1'b1;
            w_sel2 = SW'(k + 1);
            w_ld2  = (k == 0) && r_scb[k].is_load;
         end
      end
   end

   assign w_live  = bus.i_valid && !bus.i_flush;
   assign w_stall = (FORWARD != 0) ? (w_live && (w_ld1 || w_ld2))
                                   : (w_live && (w_hit1 || w_hit2));
   assign w_issue = w_live && !w_stall;

   assign bus.o_if_stall     = w_stall;
   assign bus.o_de_stall     = w_stall;
   assign bus.o_issue        = w_issue;
   assign bus.o_fwd_rs1      = (FORWARD != 0) ? w_sel1 : '0;
   assign bus.o_fwd_rs2      = (FORWARD != 0) ? w_sel2 : '0;
   assign bus.o_stall_cycles = r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NSTAGES; k++) r_scb[k] <= '0;
         r_cnt <= '0;
      end else begin
         r_scb[0].valid   <= w_issue && w_use.wback;
         r_scb[0].wreg    <= w_use.rd;
         r_scb[0].is_load <= w_use.is_load;
         for (int k = 1; k < NSTAGES; k++) r_scb[k] <= r_scb[k-1];
         if (w_stall && r_cnt != '1) r_cnt <= r_cnt + CNTW'(1);
      end
   end

endmodule
